// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: write-back request/grant bundle between the result
// sources (master side) and the write-back arbiter (slave side).
interface wb_arbiter_if;
   logic [7:0]  req;            // one request bit per write-back source
   logic [39:0] req_rd;         // 5-bit destination register per source
   logic [2:0]  WriteDataCtrl;  // write-data mux select
   logic [4:0]  WriteReg;       // register-file destination
   logic        RegWrite;       // register-file write enable
   logic [7:0]  ack;            // one-hot completion pulse
   logic        busy;           // arbiter not idle

   modport master (
      output req, req_rd,
      input  WriteDataCtrl, WriteReg, RegWrite, ack, busy
   );

   modport slave (
      input  req, req_rd,
      output WriteDataCtrl, WriteReg, RegWrite, ack, busy
   );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates eight write-back sources onto one register-file
// write port. Each transfer is a mux-settle cycle (SETUP) followed by the
// write cycle (WRITE). Arbitration policy is chosen by the macro
// WB_ARBITER_RR_EN: defined -> round-robin with a 3-bit pointer,
// undefined -> fixed priority, lowest index wins.
module wb_arbiter (
   input  logic        clk,
   input  logic        reset,
   wb_arbiter_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   logic [1:0] state_q, state_d;
   logic [2:0] win_q,   win_d;
   logic [4:0] rd_q,    rd_d;

   logic [4:0] rd_src [8];
   logic [7:0] arb_req;
   logic [2:0] arb_start;
   logic       arb_found;
   logic [2:0] arb_idx;

   // Unpack the per-source destination registers.
   for (genvar i = 0; i < 8; i++) begin : g_rd
      assign rd_src[i] = bus.req_rd[5*i +: 5];
   end

   // At the end of WRITE the just-served source is excluded from the next
   // pick so a source holding req cannot win twice back to back.
   always_comb begin
      arb_req = bus.req;
      if (state_q == ST_WRITE) begin
         arb_req = bus.req & ~(8'b1 << win_q);
      end
   end

`ifdef WB_ARBITER_RR_EN
   logic [2:0] ptr_q, ptr_d;

   // Search start: the pointer, or winner+1 when chaining out of WRITE,
   // which is exactly the value the pointer takes on that same edge.
   always_comb begin
      arb_start = ptr_q;
      if (state_q == ST_WRITE) begin
         arb_start = win_q + 3'd1;
      end
   end

   // Pointer advances only on a completed WRITE; an aborted SETUP leaves it.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_WRITE) begin
         ptr_d = win_q + 3'd1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 3'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign arb_start = 3'd0;
`endif

   // First requesting source found scanning upward from arb_start with
   // wrap; the loop runs from the far end so the nearest hit wins.
   always_comb begin
      logic [2:0] cand;
      cand      = 3'd0;
      arb_found = 1'b0;
      arb_idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         cand = arb_start + 3'(k);
         if (arb_req[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
   end

   // Transfer sequencing; rd is latched at grant so later req_rd changes
   // from the granted source have no effect.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      rd_d    = rd_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               state_d = ST_SETUP;
               win_d   = arb_idx;
               rd_d    = rd_src[arb_idx];
            end
         end
         ST_SETUP: begin
            // Requester withdrew during the settle cycle: drop the transfer.
            if (bus.req[win_q]) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (arb_found) begin
               state_d = ST_SETUP;
               win_d   = arb_idx;
               rd_d    = rd_src[arb_idx];
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and grant registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         win_q   <= 3'd0;
         rd_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         rd_q    <= rd_d;
      end
   end

   // Outputs depend on state only; everything is zero while idle.
   always_comb begin
      bus.WriteDataCtrl = 3'd0;
      bus.WriteReg      = 5'd0;
      bus.RegWrite      = 1'b0;
      bus.ack           = 8'd0;
      bus.busy          = (state_q != ST_IDLE);
      if (state_q == ST_SETUP || state_q == ST_WRITE) begin
         bus.WriteDataCtrl = win_q;
         bus.WriteReg      = rd_q;
      end
      if (state_q == ST_WRITE) begin
         // Register 0 is hardwired; the transfer completes without a write.
         bus.RegWrite = (rd_q != 5'd0);
         bus.ack      = 8'b1 << win_q;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized sources, checked every
// cycle against a transaction-level model of the arbiter. Build with
// WB_ARBITER_RR_EN defined to exercise the round-robin policy.
module tb_wb_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   wb_arbiter_if bus ();

   wb_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Phase of the current transfer: 0 nothing granted, 1 mux settling,
   // 2 writing. Grant = source index + destination captured at grant.
   int         m_phase = 0;
   int         m_win   = 0;
   int         m_ptr   = 0;
   logic [4:0] m_rd    = 5'd0;

   function automatic int pick(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

`ifdef WB_ARBITER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always @(posedge clk) begin
      logic [7:0] r;
      int w;
      if (reset) begin
         m_phase = 0; m_win = 0; m_ptr = 0; m_rd = 5'd0;
      end else if (m_phase == 0) begin
         w = pick(bus.req, RR ? m_ptr : 0);
         if (w >= 0) begin
            m_win = w; m_rd = bus.req_rd[5*w +: 5]; m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_phase = bus.req[m_win] ? 2 : 0;
      end else begin
         m_ptr = (m_win + 1) % 8;
         r = bus.req;
         r[m_win] = 1'b0;
         w = pick(r, RR ? m_ptr : 0);
         if (w >= 0) begin
            m_win = w; m_rd = bus.req_rd[5*w +: 5]; m_phase = 1;
         end else begin
            m_phase = 0;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 40'(bus.busy), 40'(m_phase != 0));
         chk("wdc",  40'(bus.WriteDataCtrl), (m_phase != 0) ? 40'(m_win) : 40'd0);
         chk("wreg", 40'(bus.WriteReg), (m_phase != 0) ? 40'(m_rd) : 40'd0);
         chk("regwrite", 40'(bus.RegWrite), 40'(m_phase == 2 && m_rd != 5'd0));
         chk("ack", 40'(bus.ack), (m_phase == 2) ? (40'd1 << m_win) : 40'd0);
      end
   end

   task automatic set_rd(input int i, input logic [4:0] v);
      bus.req_rd[5*i +: 5] = v;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int g, g5;
      bus.req = 8'd0;
      bus.req_rd = 40'd0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 40'(bus.busy), 40'd0);
      chk("rst_ack", 40'(bus.ack), 40'd0);

      // single request, rd 9
      bus.req = 8'h01; set_rd(0, 5'd9);
      @(negedge clk);
      chk("single_setup_wdc", 40'(bus.WriteDataCtrl), 40'd0);
      chk("single_setup_rw", 40'(bus.RegWrite), 40'd0);
      chk("single_setup_busy", 40'(bus.busy), 40'd1);
      @(negedge clk);
      chk("single_write_rw", 40'(bus.RegWrite), 40'd1);
      chk("single_write_wreg", 40'(bus.WriteReg), 40'd9);
      chk("single_write_ack", 40'(bus.ack), 40'h01);
      bus.req = 8'h00;
      @(negedge clk);
      chk("single_idle", 40'(bus.busy), 40'd0);

      // contention between sources 1 and 2
      bus.req = 8'h06; set_rd(1, 5'd3); set_rd(2, 5'd4);
      @(negedge clk);
      chk("cont_setup1", 40'(bus.WriteDataCtrl), 40'd1);
      @(negedge clk);
      chk("cont_ack1", 40'(bus.ack), 40'h02);
      bus.req = 8'h04;
      @(negedge clk);
      chk("cont_setup2", 40'(bus.WriteDataCtrl), 40'd2);
      chk("cont_setup2_busy", 40'(bus.busy), 40'd1);
      @(negedge clk);
      chk("cont_ack2", 40'(bus.ack), 40'h04);
      chk("cont_wreg2", 40'(bus.WriteReg), 40'd4);
      bus.req = 8'h00;
      @(negedge clk);

      // destination register 0
      bus.req = 8'h08; set_rd(3, 5'd0);
      @(negedge clk);
      chk("rd0_setup_rw", 40'(bus.RegWrite), 40'd0);
      @(negedge clk);
      chk("rd0_ack", 40'(bus.ack), 40'h08);
      chk("rd0_rw", 40'(bus.RegWrite), 40'd0);
      bus.req = 8'h00;
      @(negedge clk);

      // abort during SETUP
      bus.req = 8'h40; set_rd(6, 5'd7);
      @(negedge clk);
      chk("abort_setup", 40'(bus.WriteDataCtrl), 40'd6);
      bus.req = 8'h00;
      @(negedge clk);
      chk("abort_busy", 40'(bus.busy), 40'd0);
      chk("abort_ack", 40'(bus.ack), 40'd0);
      chk("abort_rw", 40'(bus.RegWrite), 40'd0);

      // source 0 held continuously against source 5; pointer sits at 4
      // in round-robin, so 5 goes first there and second under fixed priority
      bus.req = 8'h21; set_rd(0, 5'd1); set_rd(5, 5'd2);
      g = 0; g5 = 0;
      @(negedge clk);
      chk("starve_first", 40'(bus.WriteDataCtrl), RR ? 40'd5 : 40'd0);
      repeat (8) begin
         if (bus.ack != 8'd0) g++;
         if (bus.ack[5]) begin
            if (g5 == 0) g5 = g;
            bus.req[5] = 1'b0;
         end
         @(negedge clk);
      end
      chk("starve_grant5", 40'(g5), RR ? 40'd1 : 40'd2);
      bus.req = 8'h00;
      repeat (3) @(negedge clk);

      // reset in WRITE of source 4
      bus.req = 8'h10; set_rd(4, 5'd12);
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_ack", 40'(bus.ack), 40'h10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_busy", 40'(bus.busy), 40'd0);
      chk("rst_mid_rw", 40'(bus.RegWrite), 40'd0);
      chk("rst_mid_ack0", 40'(bus.ack), 40'd0);
      chk("rst_mid_wreg", 40'(bus.WriteReg), 40'd0);
      @(negedge clk);
      chk("rst_regrant", 40'(bus.WriteDataCtrl), 40'd4);
      @(negedge clk);
      chk("rst_regrant_ack", 40'(bus.ack), 40'h10);
      bus.req = 8'h00;
      @(negedge clk);

      // randomized sources
      repeat (3000) begin
         for (int i = 0; i < 8; i++) begin
            if (bus.req[i] && bus.ack[i]) begin
               bus.req[i] = ($urandom_range(3) == 0);
               set_rd(i, 5'($urandom));
            end else if (bus.req[i]) begin
               if ($urandom_range(40) == 0) bus.req[i] = 1'b0;
               else if ($urandom_range(10) == 0) set_rd(i, 5'($urandom));
            end else begin
               set_rd(i, 5'($urandom));
               if ($urandom_range(4) == 0) bus.req[i] = 1'b1;
            end
         end
         reset = ($urandom_range(150) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      bus.req = 8'h00;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
